// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain head driver: serialises bitstream words onto ccff_head,
// and can measure the chain length with a walking-one marker.
module ccff_bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned MAX_LEN   = 256,
  parameter int unsigned LEN_W     = 9
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start_load,
  input  logic              start_check,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  measured_len
);

  // Counters must reach MAX_LEN + 1 (the post-marker timeout point).
  localparam int unsigned CntW = $clog2(MAX_LEN + 2);
  localparam int unsigned RemW = $clog2(WORD_W + 1);

  localparam logic [CntW-1:0] ChainLen     = CntW'(CHAIN_LEN);
  localparam logic [CntW-1:0] LoadLastCnt  = CntW'(CHAIN_LEN - 1);
  localparam logic [CntW-1:0] FlushLastCnt = CntW'(MAX_LEN - 1);
  localparam logic [CntW-1:0] MaxLen       = CntW'(MAX_LEN);
  localparam logic [CntW-1:0] TimeoutCnt   = CntW'(MAX_LEN + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StMark,
    StDone,
    StError
  } state_e;

  state_e state_q, state_d;

  logic [WORD_W-1:0] sh_q, sh_d, sh_tmp;
  logic [RemW-1:0]   rem_q, rem_d, rem_tmp, take;
  logic [CntW-1:0]   acc_q, acc_d, left;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  meas_q, meas_d;

  logic start_ok, load_go, check_go;
  logic load_last, flush_last, mark_hit, mark_timeout;

  assign start_ok = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);
  assign load_go  = start_ok && start_load;
  assign check_go = start_ok && start_check && !start_load;

  // rem_q counts held bits including the one currently on ccff_head.
  assign load_last    = (state_q == StLoad) && shift_en_q && (cnt_q == LoadLastCnt);
  assign flush_last   = (state_q == StFlush) && (cnt_q == FlushLastCnt);
  assign mark_hit     = (state_q == StMark) && (cnt_q != '0) && (cnt_q <= MaxLen) && ccff_tail;
  assign mark_timeout = (state_q == StMark) && (cnt_q == TimeoutCnt);

  // Bits to take from the next word: a ragged final word keeps only its MSBs.
  assign left = ChainLen - acc_q;
  assign take = (32'(left) < WORD_W) ? RemW'(left) : RemW'(WORD_W);

  // State register
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (load_go) begin
          state_d = StLoad;
        end else if (check_go) begin
          state_d = StFlush;
        end
      end
      StLoad: begin
        if (load_last) state_d = StDone;
      end
      StFlush: begin
        if (flush_last) state_d = StMark;
      end
      StMark: begin
        if (mark_hit) begin
          state_d = (cnt_q == ChainLen) ? StDone : StError;
        end else if (mark_timeout) begin
          state_d = StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the datapath and of every registered output
  always_comb begin
    sh_d       = sh_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    s_ready_d  = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    meas_d     = meas_q;
    busy_d     = (state_d == StLoad) || (state_d == StFlush) || (state_d == StMark);
    sh_tmp     = shift_en_q ? (sh_q << 1) : sh_q;
    rem_tmp    = rem_q - RemW'(shift_en_q);

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (load_go || check_go) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          meas_d = '0;
          cnt_d  = '0;
        end
        if (load_go) begin
          acc_d     = '0;
          rem_d     = '0;
          s_ready_d = 1'b1;
        end else if (check_go) begin
          head_d     = 1'b0;
          shift_en_d = 1'b1;
        end
      end
      StLoad: begin
        cnt_d = cnt_q + CntW'(shift_en_q);
        // A new word only lands once the previous one is fully shifting out.
        if (s_valid && s_ready_q) begin
          sh_tmp  = s_data;
          rem_tmp = take;
          acc_d   = acc_q + CntW'(take);
        end
        if (load_last) begin
          rem_d  = '0;
          done_d = 1'b1;
        end else begin
          sh_d       = sh_tmp;
          rem_d      = rem_tmp;
          shift_en_d = (rem_tmp != '0);
          head_d     = (rem_tmp != '0) ? sh_tmp[WORD_W-1] : head_q;
          s_ready_d  = (rem_tmp <= RemW'(1)) && (acc_d < ChainLen);
        end
      end
      StFlush: begin
        cnt_d      = cnt_q + CntW'(1);
        shift_en_d = 1'b1;
        head_d     = 1'b0;
        if (flush_last) begin
          head_d = 1'b1;
          cnt_d  = '0;
        end
      end
      StMark: begin
        cnt_d      = cnt_q + CntW'(1);
        shift_en_d = 1'b1;
        head_d     = 1'b0;
        if (mark_hit) begin
          shift_en_d = 1'b0;
          meas_d     = LEN_W'(cnt_q);
          if (cnt_q == ChainLen) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (mark_timeout) begin
          shift_en_d = 1'b0;
          meas_d     = '0;
          err_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sh_q       <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      s_ready_q  <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      meas_q     <= '0;
    end else begin
      sh_q       <= sh_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      s_ready_q  <= s_ready_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      meas_q     <= meas_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign measured_len  = meas_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench: three loader instances (16-, 10- and 64-flop chains) each
// driving a behavioural shift-register chain model.
module tb_ccff_bitstream_loader;

  logic prog_clk = 1'b0;
  logic pReset_n = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Instance a: CHAIN_LEN 16
  logic       start_load_a = 0, start_check_a = 0, s_valid_a = 0;
  logic [7:0] s_data_a = 0;
  logic       s_ready_a, head_a, shift_en_a, busy_a, done_a, err_a, tail_a;
  logic [8:0] meas_a;
  // Instance b: CHAIN_LEN 10
  logic       start_load_b = 0, start_check_b = 0, s_valid_b = 0;
  logic [7:0] s_data_b = 0;
  logic       s_ready_b, head_b, shift_en_b, busy_b, done_b, err_b, tail_b;
  logic [8:0] meas_b;
  // Instance c: CHAIN_LEN 64, used for the length check
  logic       start_load_c = 0, start_check_c = 0, s_valid_c = 0;
  logic [7:0] s_data_c = 0;
  logic       s_ready_c, head_c, shift_en_c, busy_c, done_c, err_c, tail_c;
  logic [8:0] meas_c;

  ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8), .MAX_LEN(256), .LEN_W(9)) u_dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start_load(start_load_a),
    .start_check(start_check_a), .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .ccff_head(head_a), .ccff_shift_en(shift_en_a), .ccff_tail(tail_a), .busy(busy_a),
    .done(done_a), .err(err_a), .measured_len(meas_a)
  );
  ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(8), .MAX_LEN(256), .LEN_W(9)) u_dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start_load(start_load_b),
    .start_check(start_check_b), .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .ccff_head(head_b), .ccff_shift_en(shift_en_b), .ccff_tail(tail_b), .busy(busy_b),
    .done(done_b), .err(err_b), .measured_len(meas_b)
  );
  ccff_bitstream_loader #(.CHAIN_LEN(64), .WORD_W(8), .MAX_LEN(256), .LEN_W(9)) u_dut_c (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start_load(start_load_c),
    .start_check(start_check_c), .s_data(s_data_c), .s_valid(s_valid_c), .s_ready(s_ready_c),
    .ccff_head(head_c), .ccff_shift_en(shift_en_c), .ccff_tail(tail_c), .busy(busy_c),
    .done(done_c), .err(err_c), .measured_len(meas_c)
  );

  // Chain models and shift/bubble monitors
  logic [15:0]  chain_a = '0;
  logic [9:0]   chain_b = '0;
  logic [255:0] chain_c = '0;
  int           len_c   = 64;
  logic         stuck_c = 1'b0;
  logic [63:0]  log_a = '0, log_b = '0;
  int unsigned  nsh_a = 0, nsh_b = 0, nsh_c = 0, gap_a = 0;

  assign tail_a = chain_a[15];
  assign tail_b = chain_b[9];
  assign tail_c = stuck_c ? 1'b0 : chain_c[len_c-1];

  always @(posedge prog_clk) begin
    if (shift_en_a) begin
      chain_a <= {chain_a[14:0], head_a};
      log_a   <= {log_a[62:0], head_a};
      nsh_a   <= nsh_a + 1;
    end
    if (busy_a && !shift_en_a) gap_a <= gap_a + 1;
    if (shift_en_b) begin
      chain_b <= {chain_b[8:0], head_b};
      log_b   <= {log_b[62:0], head_b};
      nsh_b   <= nsh_b + 1;
    end
    if (shift_en_c) begin
      chain_c <= {chain_c[254:0], head_c};
      nsh_c   <= nsh_c + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? s_ready_a : s_ready_b;
  endfunction

  function automatic logic busy_of(input int sel);
    if (sel == 0) return busy_a;
    if (sel == 1) return busy_b;
    return busy_c;
  endfunction

  task automatic set_src(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      s_valid_a = v;
      s_data_a  = d;
    end else begin
      s_valid_b = v;
      s_data_b  = d;
    end
  endtask

  task automatic wait_ready(input int sel, input string tag);
    int t = 0;
    while (!ready_of(sel) && t < 64) begin
      @(negedge prog_clk);
      t++;
    end
    check_eq(tag, ready_of(sel), 1'b1);
  endtask

  // Waits for s_ready, idles `stall` cycles, then offers the word until taken.
  task automatic send_word(input int sel, input logic [7:0] d, input int stall, input string tag);
    wait_ready(sel, tag);
    repeat (stall) @(negedge prog_clk);
    set_src(sel, 1'b1, d);
    wait_ready(sel, tag);
    @(negedge prog_clk);
    set_src(sel, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int sel, input int budget, input string tag);
    int t = 0;
    while (busy_of(sel) && t < budget) begin
      @(negedge prog_clk);
      t++;
    end
    check_eq(tag, busy_of(sel), 1'b0);
  endtask

  int unsigned s0, g0;

  initial begin
    // Reset values while held in reset
    #3;
    check_eq("rst_a_outs", {s_ready_a, head_a, shift_en_a, busy_a, done_a, err_a, meas_a}, '0);
    check_eq("rst_c_outs", {s_ready_c, head_c, shift_en_c, busy_c, done_c, err_c, meas_c}, '0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
    check_eq("idle_after_rst", {busy_a, s_ready_a, shift_en_a}, '0);

    // Streaming load 0xA5, 0x3C: only the initial fill cycle is a bubble
    s0 = nsh_a; g0 = gap_a;
    start_load_a = 1'b1;
    @(negedge prog_clk);
    start_load_a = 1'b0;
    check_eq("load_busy", busy_a, 1'b1);
    send_word(0, 8'hA5, 0, "stream_rdy0");
    send_word(0, 8'h3C, 0, "stream_rdy1");
    wait_idle(0, 64, "stream_idle");
    check_eq("stream_shifts", nsh_a - s0, 16);
    check_eq("stream_gaps", gap_a - g0, 1);
    check_eq("stream_head_seq", log_a[15:0], 16'hA53C);
    check_eq("stream_chain", chain_a, 16'hA53C);
    check_eq("stream_done", {done_a, err_a, s_ready_a, shift_en_a}, 4'b1000);

    // Ragged final word: 0xFF then only the top two bits of 0x80
    s0 = nsh_b;
    start_load_b = 1'b1;
    @(negedge prog_clk);
    start_load_b = 1'b0;
    send_word(1, 8'hFF, 0, "ragged_rdy0");
    send_word(1, 8'h80, 0, "ragged_rdy1");
    wait_idle(1, 64, "ragged_idle");
    check_eq("ragged_shifts", nsh_b - s0, 10);
    check_eq("ragged_head_seq", log_b[9:0], 10'b11_1111_1110);
    check_eq("ragged_chain", chain_b, 10'b11_1111_1110);
    check_eq("ragged_done", {done_b, s_ready_b}, 2'b10);

    // Source stall of 3 cycles while s_ready is high: 3 bubbles plus the fill
    chain_a = '0;
    s0 = nsh_a; g0 = gap_a;
    start_load_a = 1'b1;
    @(negedge prog_clk);
    start_load_a = 1'b0;
    check_eq("restart_clears_done", done_a, 1'b0);
    send_word(0, 8'hA5, 0, "bubble_rdy0");
    send_word(0, 8'h3C, 3, "bubble_rdy1");
    wait_idle(0, 64, "bubble_idle");
    check_eq("bubble_shifts", nsh_a - s0, 16);
    check_eq("bubble_gaps", gap_a - g0, 4);
    check_eq("bubble_chain", chain_a, 16'hA53C);
    check_eq("bubble_done", done_a, 1'b1);

    // Length check on a healthy 64-flop chain
    s0 = nsh_c;
    start_check_c = 1'b1;
    @(negedge prog_clk);
    start_check_c = 1'b0;
    check_eq("flush_head_en", {busy_c, head_c, shift_en_c}, 3'b101);
    wait_idle(2, 1000, "chk64_idle");
    check_eq("chk64_shifts", nsh_c - s0, 256 + 1 + 64);
    check_eq("chk64_len", meas_c, 64);
    check_eq("chk64_flags", {done_c, err_c}, 2'b10);

    // Chain one flop short
    len_c = 63;
    s0 = nsh_c;
    start_check_c = 1'b1;
    @(negedge prog_clk);
    start_check_c = 1'b0;
    check_eq("chk63_cleared", {done_c, err_c, meas_c}, '0);
    wait_idle(2, 1000, "chk63_idle");
    check_eq("chk63_shifts", nsh_c - s0, 256 + 1 + 63);
    check_eq("chk63_len", meas_c, 63);
    check_eq("chk63_flags", {done_c, err_c}, 2'b01);

    // Broken chain: tail stuck at 0 times out after MAX_LEN+1 post-marker shifts
    stuck_c = 1'b1;
    s0 = nsh_c;
    start_check_c = 1'b1;
    @(negedge prog_clk);
    start_check_c = 1'b0;
    wait_idle(2, 1000, "stuck_idle");
    check_eq("stuck_shifts", nsh_c - s0, 256 + 1 + 257);
    check_eq("stuck_len", meas_c, 0);
    check_eq("stuck_flags", {done_c, err_c}, 2'b01);
    stuck_c = 1'b0;

    // Both starts together: load wins (s_ready up, no flush shifting)
    start_load_a  = 1'b1;
    start_check_a = 1'b1;
    @(negedge prog_clk);
    start_load_a  = 1'b0;
    start_check_a = 1'b0;
    check_eq("both_starts_load", {busy_a, s_ready_a, shift_en_a}, 3'b110);
    // start_check while busy is ignored
    start_check_a = 1'b1;
    @(negedge prog_clk);
    start_check_a = 1'b0;
    check_eq("check_ignored", {busy_a, s_ready_a, shift_en_a}, 3'b110);
    send_word(0, 8'hA5, 0, "midload_rdy");
    @(negedge prog_clk);
    check_eq("midload_shifting", {busy_a, shift_en_a}, 2'b11);

    // Asynchronous reset mid-load, away from any clock edge
    #2;
    pReset_n = 1'b0;
    #1;
    check_eq("async_rst_outs",
             {s_ready_a, head_a, shift_en_a, busy_a, done_a, err_a, meas_a}, '0);
    check_eq("async_rst_c", {done_c, err_c, meas_c}, '0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    repeat (2) @(negedge prog_clk);
    check_eq("post_rst_idle", {busy_a, s_ready_a, shift_en_a, done_a}, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Drives one configuration-chain segment from the head end: accepts a bitstream as parallel words, serialises it onto `ccff_head`, and gates shifting via `ccff_shift_en`.
- Observes the far end of the chain on `ccff_tail`.
- Also provides a chain-integrity check mode that measures the chain length with a walking-one marker before configuration.
- Sits between the bitstream source (DMA/JTAG word port) and the tile chain (IO/CLB tiles linked head-to-tail).

Parameters:
- `CHAIN_LEN`, default 64: number of configuration flops expected in the chain (≥ 1).
- `WORD_W`, default 8: bitstream word width (≥ 1).
- `MAX_LEN`, default 256: check-mode flush length and timeout bound (≥ `CHAIN_LEN`).
- `LEN_W`, default 9: width of `measured_len`, equal to clog2(`MAX_LEN`+1).

Ports:
- `prog_clk`, input, 1: programming clock; all state updates on its rising edge.
- `pReset_n`, input, 1: asynchronous active-low reset.
- `start_load`, input, 1: one-cycle request to load `CHAIN_LEN` bits; honoured only in IDLE or DONE/ERROR.
- `start_check`, input, 1: one-cycle request to run the chain-length check; same acceptance rule as `start_load`.
- `s_data`, input, `WORD_W`: bitstream word, MSB shifted first.
- `s_valid`, input, 1: `s_data` valid.
- `s_ready`, output, 1: word accepted on any edge where `s_valid` and `s_ready` are both 1.
- `ccff_head`, output, 1: serial data into the chain.
- `ccff_shift_en`, output, 1: chain shifts (captures `ccff_head`) on edges where this is 1.
- `ccff_tail`, input, 1: serial output of the last chain flop.
- `busy`, output, 1: high in LOAD, FLUSH, MARK.
- `done`, output, 1: operation completed successfully.
- `err`, output, 1: check failed or timed out.
- `measured_len`, output, `LEN_W`: chain length found by the last check.

Behaviour:
- **Reset values.** Async assert, sync-free release. State IDLE. `s_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `err`=0, `measured_len`=0. Reset mid-operation aborts immediately; no partial-state recovery.
- **Registered outputs.** All outputs are registered. `ccff_head` and `ccff_shift_en` change on the same edge. A "shift edge" is a `prog_clk` edge with `ccff_shift_en`=1.
- **States.** IDLE, LOAD, FLUSH, MARK, DONE, ERROR.
- **Start acceptance.**
  - Starts are accepted in IDLE, DONE or ERROR; they are ignored while `busy`.
  - `start_load` and `start_check` together: load wins.
  - Acceptance clears `done` and `err`.
- **LOAD.**
  - `s_ready`=1 when the word register is empty, or when it holds exactly one remaining bit and that bit is shifting this cycle. This gives gap-free back-to-back streaming.
  - `s_ready`=0 once `CHAIN_LEN` bits have been accepted.
  - Each held bit is presented with `ccff_shift_en`=1 for exactly one cycle.
  - If the word register is empty, `ccff_shift_en`=0 and `ccff_head` holds its last value (bubble; the chain does not shift).
  - Bit counter from 0 to `CHAIN_LEN`. If `CHAIN_LEN` is not a multiple of `WORD_W`, the unused LSBs of the final word are discarded.
  - After the `CHAIN_LEN`-th shift edge: go to DONE, `ccff_shift_en`=0, `done`=1.
  - Exactly `CHAIN_LEN` shift edges occur per load.
- **FLUSH (check).**
  - `ccff_head`=0 and `ccff_shift_en`=1 for `MAX_LEN` consecutive cycles.
  - `ccff_tail` is ignored during FLUSH.
- **MARK (check).**
  - Shift edge 0 shifts `ccff_head`=1 (the marker); every later shift edge shifts 0.
  - Counter n counts shift edges after the marker edge. At each shift edge n ≥ 1, sample `ccff_tail`.
  - First sample equal to 1: `measured_len` = n, stop shifting.
    - If n = `CHAIN_LEN`: go to DONE, `done`=1.
    - Otherwise: go to ERROR, `err`=1.
  - n reaches `MAX_LEN`+1 with no 1 seen: `measured_len`=0, go to ERROR, `err`=1 (broken chain).
  - For a healthy chain of L flops, the marker is sampled on `ccff_tail` at n = L.
- **Output persistence.** `done`, `err` and `measured_len` hold until the next accepted start or reset. `s_ready`=0 outside LOAD.
- **Width rule.** All counters saturate-free; they are sized to hold `MAX_LEN`+1.

Test Plan:
- **Streaming load.** Reset; `CHAIN_LEN`=16, `WORD_W`=8; `start_load`; feed 0xA5 then 0x3C with `s_valid` held. Expect 16 consecutive shift edges with no bubble, `ccff_head` sequence 1010_0101_0011_1100, then `done`=1, `s_ready`=0, and the chain model contents equal the stream.
- **Ragged last word.** `CHAIN_LEN`=10, `WORD_W`=8; words 0xFF, 0x80. Expect exactly 10 shift edges (8 ones, then 1, 0); the 6 LSBs of 0x80 are dropped.
- **Source bubbles.** Stall `s_valid` for 3 cycles between words. Expect `ccff_shift_en`=0 for the stall cycles, no extra shifts, and identical chain contents.
- **Check pass and fail.**
  - Chain model of 64 flops: `start_check` → `MAX_LEN` zero shifts, marker, then `measured_len`=64, `done`=1.
  - Model of 63 flops → `measured_len`=63, `err`=1.
  - `ccff_tail` stuck 0 → `err`=1 and `measured_len`=0 after `MAX_LEN`+1 post-marker shifts.
- **Control corners.**
  - `start_load` and `start_check` in the same cycle → LOAD.
  - `start_check` during LOAD → ignored.
  - `pReset_n` asserted mid-LOAD → all outputs at reset values within the same cycle; state IDLE.
